rgb_symbol_scheduler: RTL and testbench

RGB_SYMBOL_SCHEDULER -- requirements
Module: rgb_symbol_scheduler

---
 rtl/rgb_sched_pkg.sv | 22 ++
 rtl/rgb_sym_timer.sv | 40 ++++
 rtl/rgb_symbol_scheduler.sv | 173 +++++++++++++++++
 tb/tb_rgb_symbol_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_sched_pkg.sv
// Shared encodings and index constants for the RGB symbol scheduler.
// The pilot feature of the scheduler is enabled by the RGB_PILOT_EN macro.
package rgb_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam logic [5:0] IDLE_INDEX  = 6'd0;
    localparam logic [5:0] PILOT_INDEX = 6'd63;
    localparam logic [5:0] PREAMBLE_HI = 6'd63;
    localparam logic [5:0] PREAMBLE_LO = 6'd0;

    // Preamble alternates HI,LO,HI,... so odd-numbered symbols are LO.
    function automatic logic [5:0] preamble_index(input logic odd);
        return odd ? PREAMBLE_LO : PREAMBLE_HI;
    endfunction

endpackage

// File: rtl/rgb_sym_timer.sv
// Symbol period counter: strobe on the first cycle and last-cycle flag of
// every SYM_PERIOD-cycle symbol while enabled; held at 0 when disabled.
module rgb_sym_timer #(
    parameter int SYM_PERIOD = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic sym_strobe,
    output logic sym_last
);

    localparam int CW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SYM_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sym_strobe = en && (cnt_q == '0);
    assign sym_last   = en && (cnt_q == LAST);

endmodule

// File: rtl/rgb_symbol_scheduler.sv
// Frame scheduler: preamble, data (through a one-entry holding register), gap.
// Define RGB_PILOT_EN to insert a pilot symbol every PILOT_INTERVAL data symbols.
module rgb_symbol_scheduler
    import rgb_sched_pkg::*;
#(
    parameter int SYM_PERIOD     = 16,
    parameter int PREAMBLE_LEN   = 8,
    parameter int GAP_LEN        = 4,
    parameter int PILOT_INTERVAL = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic       s_valid,
    input  logic [5:0] s_index,
    output logic       s_ready,
    output logic [5:0] index,
    output logic       sym_strobe,
    output logic       busy,
    output logic       done,
    output logic       underflow
);

`ifdef RGB_PILOT_EN
    localparam bit PILOT_EN = 1'b1;
`else
    localparam bit PILOT_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [5:0] index_q, index_d;
    logic [5:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] acc_left_q, acc_left_d;
    logic [7:0] data_left_q, data_left_d;
    logic [7:0] sym_cnt_q, sym_cnt_d;
    logic [7:0] since_pilot_q, since_pilot_d;
    logic       underflow_q, underflow_d;
    logic       sym_last, accept, emit_data, pilot_due;

    rgb_sym_timer #(.SYM_PERIOD(SYM_PERIOD)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .en         (busy),
        .sym_strobe (sym_strobe),
        .sym_last   (sym_last)
    );

    assign busy      = (state_q != ST_IDLE);
    assign s_ready   = busy && !hold_vld_q && (acc_left_q != 8'd0);
    assign accept    = s_valid && s_ready;
    assign pilot_due = PILOT_EN && (since_pilot_q == 8'(PILOT_INTERVAL));
    assign index     = index_q;
    assign underflow = underflow_q;

    // All symbol decisions are taken on the last cycle of the current symbol.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        acc_left_d    = acc_left_q;
        data_left_d   = data_left_q;
        sym_cnt_d     = sym_cnt_q;
        since_pilot_d = since_pilot_q;
        underflow_d   = underflow_q;
        emit_data     = 1'b0;
        done          = 1'b0;

        if (accept) begin
            hold_d     = s_index;
            hold_vld_d = 1'b1;
            acc_left_d = acc_left_q - 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_PREAMBLE;
                    index_d       = PREAMBLE_HI;
                    acc_left_d    = frame_len;
                    data_left_d   = frame_len;
                    sym_cnt_d     = 8'd0;
                    since_pilot_d = 8'd0;
                    underflow_d   = 1'b0;
                    hold_vld_d    = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (sym_last) begin
                    if (sym_cnt_q != 8'(PREAMBLE_LEN - 1)) begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                        index_d   = preamble_index(~sym_cnt_q[0]);
                    end else if (data_left_q == 8'd0) begin
                        state_d   = ST_GAP;
                        sym_cnt_d = 8'd0;
                        index_d   = IDLE_INDEX;
                    end else begin
                        state_d   = ST_DATA;
                        emit_data = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (sym_last) begin
                    if (data_left_q == 8'd0) begin
                        state_d   = ST_GAP;
                        sym_cnt_d = 8'd0;
                        index_d   = IDLE_INDEX;
                    end else if (pilot_due) begin
                        index_d       = PILOT_INDEX;
                        since_pilot_d = 8'd0;
                    end else begin
                        emit_data = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (sym_last) begin
                    if (sym_cnt_q == 8'(GAP_LEN - 1)) begin
                        state_d = ST_IDLE;
                        index_d = IDLE_INDEX;
                        done    = 1'b1;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An empty holding register at a data boundary sends a fill symbol.
        if (emit_data) begin
            if (hold_vld_q) begin
                index_d     = hold_q;
                hold_vld_d  = 1'b0;
                data_left_d = data_left_q - 8'd1;
                if (since_pilot_q != 8'hFF) begin
                    since_pilot_d = since_pilot_q + 8'd1;
                end
            end else begin
                index_d     = IDLE_INDEX;
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            index_q       <= IDLE_INDEX;
            hold_q        <= 6'd0;
            hold_vld_q    <= 1'b0;
            acc_left_q    <= 8'd0;
            data_left_q   <= 8'd0;
            sym_cnt_q     <= 8'd0;
            since_pilot_q <= 8'd0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            acc_left_q    <= acc_left_d;
            data_left_q   <= data_left_d;
            sym_cnt_q     <= sym_cnt_d;
            since_pilot_q <= since_pilot_d;
            underflow_q   <= underflow_d;
        end
    end

endmodule

// File: tb/tb_rgb_symbol_scheduler.sv
// Scoreboard bench for rgb_symbol_scheduler (SYM_PERIOD=4, PREAMBLE_LEN=2,
// GAP_LEN=1, PILOT_INTERVAL=2); expectations follow RGB_PILOT_EN if defined.
module tb_rgb_symbol_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] frame_len;
    logic       s_valid;
    logic [5:0] s_index;
    logic       s_ready;
    logic [5:0] index;
    logic       sym_strobe;
    logic       busy;
    logic       done;
    logic       underflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [5:0] exp_q[$];
    logic [5:0] src_q[$];
    logic [5:0] exp_v;
    logic [5:0] prev_index = 6'd0;
    bit         prev_rst_ok = 1'b0;

    always #5 clk = ~clk;

    rgb_symbol_scheduler #(
        .SYM_PERIOD     (4),
        .PREAMBLE_LEN   (2),
        .GAP_LEN        (1),
        .PILOT_INTERVAL (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .frame_len  (frame_len),
        .s_valid    (s_valid),
        .s_index    (s_index),
        .s_ready    (s_ready),
        .index      (index),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .done       (done),
        .underflow  (underflow)
    );

    // Scoreboard: every symbol strobe pops one expected index; between
    // strobes the index must hold its value.
    initial begin
        forever begin
            @(negedge clk);
            if (sym_strobe) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL symbol: got index %0d, no symbol expected", index);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (index !== exp_v) begin
                        errors++;
                        $display("FAIL symbol: got index %0d, expected %0d", index, exp_v);
                    end
                end
            end else if (resetn && prev_rst_ok) begin
                checks++;
                if (index !== prev_index) begin
                    errors++;
                    $display("FAIL index_hold: index %0d changed from %0d without strobe", index, prev_index);
                end
            end
            prev_index  = index;
            prev_rst_ok = resetn;
        end
    end

    // Advance one cycle and present the head of src_q unless inside the drop window.
    task automatic step(input int drop_lo, input int drop_hi);
        @(negedge clk);
        cyc++;
        s_valid = (src_q.size() > 0) && !(cyc >= drop_lo && cyc < drop_hi);
        s_index = (src_q.size() > 0) ? src_q[0] : 6'd0;
        if (s_valid && s_ready) void'(src_q.pop_front());
    endtask

    task automatic run_frame(input int flen, input int drop_lo, input int drop_hi,
                             input int restart_at, output int done_cyc,
                             output bit rdy_seen, output bit ufl_c2);
        done_cyc = -1;
        rdy_seen = 1'b0;
        ufl_c2   = 1'b0;
        @(negedge clk);
        cyc       = 0;
        start     = 1'b1;
        frame_len = flen[7:0];
        for (int i = 0; i < 200 && done_cyc < 0; i++) begin
            step(drop_lo, drop_hi);
            start = (cyc == restart_at);
            if (start) frame_len = 8'(flen + 2);
            if (s_ready) rdy_seen = 1'b1;
            if (cyc == 2) ufl_c2 = underflow;
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        repeat (2) step(-1, -1);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({index, s_ready, sym_strobe, busy, done, underflow} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got index=%0d s_ready=%0b strobe=%0b busy=%0b done=%0b underflow=%0b, expected all 0",
                     index, s_ready, sym_strobe, busy, done, underflow);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({index, busy, sym_strobe, s_ready} !== 9'd0) begin
            errors++;
            $display("FAIL idle_outputs: got index=%0d busy=%0b strobe=%0b s_ready=%0b, expected 0",
                     index, busy, sym_strobe, s_ready);
        end
    endtask

    task automatic test_basic();
        int dc; bit rdy, u2;
        src_q = '{6'd5, 6'd9, 6'd42};
        exp_q = '{6'd63, 6'd0, 6'd5, 6'd9, 6'd42, 6'd0};
        run_frame(3, -1, -1, -1, dc, rdy, u2);
        checks++;
        if (dc != 24) begin errors++; $display("FAIL basic_done_cycle: got %0d, expected 24", dc); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL basic_underflow: got %0b, expected 0", underflow); end
        checks++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: %0d symbols unsent, %0d indices unaccepted, expected 0", exp_q.size(), src_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%0b, expected 0", busy); end
    endtask

    task automatic test_zero_len();
        int dc; bit rdy, u2;
        src_q = '{6'd7};
        exp_q = '{6'd63, 6'd0, 6'd0};
        run_frame(0, -1, -1, -1, dc, rdy, u2);
        checks++;
        if (dc != 12) begin errors++; $display("FAIL zero_done_cycle: got %0d, expected 12", dc); end
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL zero_s_ready: s_ready seen=%0b, expected 0", rdy); end
        checks++;
        if (src_q.size() != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_drain: src left %0d (expected 1), symbols unsent %0d (expected 0)", src_q.size(), exp_q.size());
        end
        src_q.delete();
    endtask

    task automatic test_underflow();
        int dc; bit rdy, u2;
        src_q = '{6'd5, 6'd9, 6'd42};
        exp_q = '{6'd63, 6'd0, 6'd5, 6'd0, 6'd9, 6'd42, 6'd0};
        run_frame(3, 9, 15, -1, dc, rdy, u2);
        checks++;
        if (dc != 28) begin errors++; $display("FAIL ufl_done_cycle: got %0d, expected 28", dc); end
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL ufl_flag: got %0b, expected 1", underflow); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ufl_drain: %0d symbols unsent, expected 0", exp_q.size()); end
        src_q = '{6'd1, 6'd2, 6'd3};
        exp_q = '{6'd63, 6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
        run_frame(3, -1, -1, -1, dc, rdy, u2);
        checks++;
        if (u2 !== 1'b0) begin errors++; $display("FAIL ufl_clear: underflow after start=%0b, expected 0", u2); end
        checks++;
        if (underflow !== 1'b0 || dc != 24) begin
            errors++;
            $display("FAIL ufl_next_frame: underflow=%0b done cycle=%0d, expected 0 and 24", underflow, dc);
        end
    endtask

    task automatic test_start_ignored();
        int dc; bit rdy, u2;
        src_q = '{6'd17, 6'd34, 6'd51};
        exp_q = '{6'd63, 6'd0, 6'd17, 6'd34, 6'd51, 6'd0};
        run_frame(3, -1, -1, 14, dc, rdy, u2);
        checks++;
        if (dc != 24) begin errors++; $display("FAIL start_ignored_done: got %0d, expected 24", dc); end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_drain: unsent %0d busy=%0b, expected 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int dc; bit rdy, u2; bit done_seen;
        src_q = '{6'd5, 6'd9, 6'd42};
        exp_q = '{6'd63, 6'd0, 6'd5, 6'd9};
        @(negedge clk);
        cyc       = 0;
        start     = 1'b1;
        frame_len = 8'd3;
        repeat (13) begin
            step(-1, -1);
            start = 1'b0;
        end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({index, busy, s_ready} !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: index=%0d busy=%0b s_ready=%0b, expected 0", index, busy, s_ready);
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        s_valid = 1'b0;
        src_q.delete();
        resetn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin errors++; $display("FAIL reset_mid_done: done seen=%0b, expected 0", done_seen); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_sent: %0d symbols unsent, expected 0", exp_q.size()); end
        src_q = '{6'd5, 6'd9, 6'd42};
        exp_q = '{6'd63, 6'd0, 6'd5, 6'd9, 6'd42, 6'd0};
        run_frame(3, -1, -1, -1, dc, rdy, u2);
        checks++;
        if (dc != 24 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_rerun: done cycle=%0d unsent=%0d, expected 24 and 0", dc, exp_q.size());
        end
    endtask

    task automatic test_pilot();
        int dc; bit rdy, u2; int exp_dc;
        src_q = '{6'd11, 6'd22, 6'd33, 6'd44, 6'd55};
`ifdef RGB_PILOT_EN
        exp_q  = '{6'd63, 6'd0, 6'd11, 6'd22, 6'd63, 6'd33, 6'd44, 6'd63, 6'd55, 6'd0};
        exp_dc = 40;
`else
        exp_q  = '{6'd63, 6'd0, 6'd11, 6'd22, 6'd33, 6'd44, 6'd55, 6'd0};
        exp_dc = 32;
`endif
        run_frame(5, -1, -1, -1, dc, rdy, u2);
        checks++;
        if (dc != exp_dc) begin errors++; $display("FAIL pilot_done_cycle: got %0d, expected %0d", dc, exp_dc); end
        checks++;
        if (exp_q.size() != 0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL pilot_drain: unsent %0d underflow=%0b, expected 0 and 0", exp_q.size(), underflow);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        frame_len = 8'd0;
        s_valid   = 1'b0;
        s_index   = 6'd0;
        test_reset();
        test_basic();
        test_zero_len();
        test_underflow();
        test_start_ignored();
        test_reset_mid();
        test_pilot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
